// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory read-modify-write controller:
// FSM state encoding, size-mask constants and mask classification helpers.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [2:0] MASK_BYTE = 3'b001;
    localparam logic [2:0] MASK_HALF = 3'b011;
    localparam logic [2:0] MASK_WORD = 3'b111;
    localparam int         SIGN_BIT  = 3;

    // Only the three contiguous size masks describe a real access width.
    function automatic logic mask_legal(input logic [3:0] sign_mask);
        return (sign_mask[2:0] == MASK_BYTE) ||
               (sign_mask[2:0] == MASK_HALF) ||
               (sign_mask[2:0] == MASK_WORD);
    endfunction

    // Byte accesses can never be misaligned; halves need bit 0 clear, words bits 1:0.
    function automatic logic is_misaligned(input logic [3:0] sign_mask, input logic [1:0] addr_lo);
        return ((sign_mask[2:0] == MASK_HALF) && addr_lo[0]) ||
               ((sign_mask[2:0] == MASK_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: extracts and extends load data from a RAM word,
// and merges sub-word store data into the word read back from RAM.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  sign_mask,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [2:0]  size;
    logic        sign_en;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] wdata_rep;
    logic [3:0]  lane_hit;

    assign size     = sign_mask[2:0];
    assign sign_en  = sign_mask[SIGN_BIT];
    assign byte_sel = word[{addr_lo, 3'b000} +: 8];
    assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

    // Replicate store data across the word so every lane sees its own copy.
    always_comb begin
        wdata_rep = wdata;
        case (size)
            MASK_BYTE: wdata_rep = {4{wdata[7:0]}};
            MASK_HALF: wdata_rep = {2{wdata[15:0]}};
            default:   wdata_rep = wdata;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_hit[gi] = (size == MASK_WORD) ||
                                  ((size == MASK_HALF) && (addr_lo[1] == 1'(gi / 2))) ||
                                  ((size == MASK_BYTE) && (addr_lo == 2'(gi)));
            assign store_word[gi*8 +: 8] = lane_hit[gi] ? wdata_rep[gi*8 +: 8] : word[gi*8 +: 8];
        end
    endgenerate

    // Select the addressed lane and extend with the sign bit or zeros.
    always_comb begin
        load_data = word;
        case (size)
            MASK_BYTE: load_data = {{24{sign_en & byte_sel[7]}}, byte_sel};
            MASK_HALF: load_data = {{16{sign_en & half_sel[15]}}, half_sel};
            default:   load_data = word;
        endcase
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory access controller between the load/store stage and a word-wide
// single-port RAM without byte enables. Sub-word stores use read-modify-write.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (trap misaligned accesses
// instead of aligning them down).
module dmem_rmw_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_sign_mask,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t              state_reg;
    state_t              state_next;

    logic                we_reg;
    logic [ADDR_W+1:0]   addr_reg;
    logic [31:0]         wdata_reg;
    logic [3:0]          mask_reg;
    logic [31:0]         wword_reg;
    logic [31:0]         rdata_reg;
    logic                err_reg;

    logic                req_legal;
    logic                req_misal;
    logic                req_trap;
    logic                req_fault;
    logic [ADDR_W+1:0]   req_addr_aligned;
    logic [31:0]         load_data;
    logic [31:0]         store_word;
    logic                unused_addr_bits;

    assign req_legal = mask_legal(req_sign_mask);
    assign req_misal = is_misaligned(req_sign_mask, req_addr[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign req_trap = req_misal;
`else
    assign req_trap = 1'b0;
`endif

    assign req_fault = !req_legal || req_trap;

    // Bits above the RAM index are ignored, so the address wraps around.
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Misaligned halves/words are forced onto their natural boundary.
    always_comb begin
        req_addr_aligned = req_addr[ADDR_W+1:0];
        if (req_misal) begin
            if (req_sign_mask[2:0] == MASK_WORD) begin
                req_addr_aligned[1:0] = 2'b00;
            end else begin
                req_addr_aligned[0] = 1'b0;
            end
        end
    end

    dmem_lane_unit u_lane (
        .word       (mem_rdata),
        .addr_lo    (addr_reg[1:0]),
        .sign_mask  (mask_reg),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and state-derived strobes/response outputs.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault) begin
                        state_next = ST_RESP;
                    end else if (req_we && (req_sign_mask[2:0] == MASK_WORD)) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_rd     = 1'b1;
                mem_addr   = addr_reg[ADDR_W+1:2];
                state_next = ST_MERGE;
            end
            ST_MERGE: begin
                state_next = we_reg ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                mem_wr     = 1'b1;
                mem_addr   = addr_reg[ADDR_W+1:2];
                mem_wdata  = wword_reg;
                rsp_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = rdata_reg;
                rsp_err    = err_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request capture in IDLE and load/merge result capture in MERGE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            mask_reg  <= '0;
            wword_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if ((state_reg == ST_IDLE) && req_valid) begin
                we_reg    <= req_we;
                addr_reg  <= req_addr_aligned;
                wdata_reg <= req_wdata;
                mask_reg  <= req_sign_mask;
                wword_reg <= req_wdata;
                rdata_reg <= '0;
                err_reg   <= req_fault;
            end else if (state_reg == ST_MERGE) begin
                if (we_reg) begin
                    wword_reg <= store_word;
                end else begin
                    rdata_reg <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Self-checking bench for dmem_rmw_ctrl: a cycle-indexed behavioural model
// predicts strobes and responses from the access rules; literal expectations
// pin the model on the directed vectors.
module tb_dmem_rmw_ctrl;

    localparam int          ADDR_W   = 10;
    localparam int          PRE_IDX  = 4;
    localparam logic [31:0] PRE_WORD = 32'hA1B2C3D4;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_sign_mask;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    dmem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_sign_mask (req_sign_mask),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one-cycle read latency.
    logic [31:0] ram [0:1023];
    bit do_preload = 1'b0;
    always @(posedge clk) begin
        if (do_preload) ram[PRE_IDX] <= PRE_WORD;
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    // Model state, keyed by the cycle in which each event must be visible.
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_rsp_data [int];
    logic        exp_rsp_err  [int];
    int          exp_rd_addr  [int];
    int          exp_wr_addr  [int];
    logic [31:0] exp_wr_data  [int];
    logic [31:0] lit_rdata    [int];
    logic        lit_err      [int];
    logic [31:0] lit_wdata    [int];
    int busy_from  = -1;
    int busy_until = -1;
    bit chk_idle   = 1'b0;
    bit chk_abort  = 1'b0;
    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Single compare process, runs on every falling edge.
    always @(negedge clk) begin
        if (do_preload) ref_mem[PRE_IDX] = PRE_WORD;
        chk("req_ready", 32'(req_ready), 32'(!(cyc >= busy_from && cyc <= busy_until)));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_data.exists(cyc)));
        chk("mem_rd", 32'(mem_rd), 32'(exp_rd_addr.exists(cyc)));
        chk("mem_wr", 32'(mem_wr), 32'(exp_wr_addr.exists(cyc)));
        if (exp_rsp_data.exists(cyc)) begin
            chk("rsp_rdata", rsp_rdata, exp_rsp_data[cyc]);
            chk("rsp_err", 32'(rsp_err), 32'(exp_rsp_err[cyc]));
        end
        if (exp_rd_addr.exists(cyc)) chk("rd_addr", 32'(mem_addr), 32'(exp_rd_addr[cyc]));
        if (exp_wr_addr.exists(cyc)) begin
            chk("wr_addr", 32'(mem_addr), 32'(exp_wr_addr[cyc]));
            chk("wr_data", mem_wdata, exp_wr_data[cyc]);
            ref_mem[exp_wr_addr[cyc]] = exp_wr_data[cyc];
        end
        if (lit_rdata.exists(cyc)) begin
            chk("lit_rdata", rsp_rdata, lit_rdata[cyc]);
            chk("lit_err", 32'(rsp_err), 32'(lit_err[cyc]));
        end
        if (lit_wdata.exists(cyc)) chk("lit_wdata", mem_wdata, lit_wdata[cyc]);
        if (chk_idle) begin
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_rsp_rdata", rsp_rdata, 32'd0);
            chk("idle_rsp_err", 32'(rsp_err), 32'd0);
            chk("idle_mem_rd", 32'(mem_rd), 32'd0);
            chk("idle_mem_wr", 32'(mem_wr), 32'd0);
            chk("idle_mem_addr", 32'(mem_addr), 32'd0);
            chk("idle_mem_wdata", mem_wdata, 32'd0);
            chk("idle_req_ready", 32'(req_ready), 32'd1);
        end
        if (chk_abort) chk("abort_ram", ram[PRE_IDX], PRE_WORD);
    end

    // Issue one request and record what the model says must happen.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, output int rc, output int wc);
        int k;
        int n;
        int idx;
        int sh;
        logic [2:0]  sz;
        bit          legal;
        bit          misal;
        bit          trap;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] m;
        @(negedge clk);
        #1;
        k = 0;
        while (!req_ready) begin
            if (k == 50) begin
                $display("FAIL ready_timeout cycle %0d: got req_ready 0 expected 1", cyc);
                $fatal(1, "request never accepted");
            end
            @(negedge clk);
            #1;
            k++;
        end
        n = cyc;
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = wdata;
        req_sign_mask = mask;
        sz = mask[2:0];
        legal = (sz == 3'b001) || (sz == 3'b011) || (sz == 3'b111);
        misal = ((sz == 3'b011) && addr[0]) || ((sz == 3'b111) && (addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = misal;
`else
        trap = 1'b0;
`endif
        wc = -1;
        v = 32'd0;
        if (!legal || trap) begin
            rc = n + 1;
            exp_rsp_data[rc] = 32'd0;
            exp_rsp_err[rc] = 1'b1;
        end else begin
            a = addr;
            if (sz == 3'b111) a[1:0] = 2'b00;
            else if (sz == 3'b011) a[0] = 1'b0;
            idx = int'((a >> 2) % 1024);
            sh = 8 * int'(a % 4);
            if (we && sz == 3'b111) begin
                rc = n + 1;
                wc = n + 1;
                exp_wr_addr[wc] = idx;
                exp_wr_data[wc] = wdata;
            end else begin
                exp_rd_addr[n+1] = idx;
                rc = n + 3;
                w = ref_mem[idx];
                if (we) begin
                    m = (sz == 3'b001) ? 32'hFF : 32'hFFFF;
                    wc = n + 3;
                    exp_wr_addr[wc] = idx;
                    exp_wr_data[wc] = (w & ~(m << sh)) | ((wdata & m) << sh);
                end else if (sz == 3'b111) begin
                    v = w;
                end else if (sz == 3'b011) begin
                    v = (w >> sh) & 32'hFFFF;
                    if (mask[3] && v[15]) v = v | 32'hFFFF0000;
                end else begin
                    v = (w >> sh) & 32'hFF;
                    if (mask[3] && v[7]) v = v | 32'hFFFFFF00;
                end
            end
            exp_rsp_data[rc] = v;
            exp_rsp_err[rc] = 1'b0;
        end
        busy_from = n + 1;
        busy_until = rc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Issue, attach literal expectations, wait until the response cycle is past.
    task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [31:0] l_rdata, input logic l_err,
                       input bit l_w_on, input logic [31:0] l_wdata);
        int rc;
        int wc;
        issue(we, addr, wdata, mask, rc, wc);
        lit_rdata[rc] = l_rdata;
        lit_err[rc] = l_err;
        if (l_w_on && wc >= 0) lit_wdata[wc] = l_wdata;
        while (cyc <= rc) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic preload();
        @(negedge clk);
        #1;
        do_preload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        do_preload = 1'b0;
    endtask

    task automatic pulse_idle_check(input bit abort_too);
        @(negedge clk);
        #1;
        chk_idle = 1'b1;
        chk_abort = abort_too;
        @(negedge clk);
        #1;
        chk_idle = 1'b0;
        chk_abort = 1'b0;
    endtask

    initial begin
        int rc;
        int wc;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_sign_mask = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        pulse_idle_check(1'b0);

        preload();
        run(1'b0, 32'h13, 32'h0, 4'b1001, 32'hFFFFFFA1, 1'b0, 1'b0, 32'h0);
        run(1'b0, 32'h13, 32'h0, 4'b0001, 32'h000000A1, 1'b0, 1'b0, 32'h0);
        run(1'b0, 32'h10, 32'h0, 4'b1011, 32'hFFFFC3D4, 1'b0, 1'b0, 32'h0);
        run(1'b0, 32'h12, 32'h0, 4'b0011, 32'h0000A1B2, 1'b0, 1'b0, 32'h0);
        run(1'b0, 32'h10, 32'h0, 4'b1001, 32'hFFFFFFD4, 1'b0, 1'b0, 32'h0);
        run(1'b0, 32'h1010, 32'h0, 4'b0111, 32'hA1B2C3D4, 1'b0, 1'b0, 32'h0);

        run(1'b1, 32'h11, 32'hFFFFFF55, 4'b0001, 32'h0, 1'b0, 1'b1, 32'hA1B255D4);
        run(1'b0, 32'h10, 32'h0, 4'b0111, 32'hA1B255D4, 1'b0, 1'b0, 32'h0);

        preload();
        run(1'b1, 32'h10, 32'hDEADBEEF, 4'b0111, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        run(1'b0, 32'h10, 32'h0, 4'b0111, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);

        preload();
        run(1'b1, 32'h12, 32'h00001234, 4'b1011, 32'h0, 1'b0, 1'b1, 32'h1234C3D4);

        preload();
`ifdef DMEM_MISALIGN_TRAP_EN
        run(1'b0, 32'h11, 32'h0, 4'b1011, 32'h0, 1'b1, 1'b0, 32'h0);
`else
        run(1'b0, 32'h11, 32'h0, 4'b1011, 32'hFFFFC3D4, 1'b0, 1'b0, 32'h0);
`endif
        run(1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0);
        run(1'b1, 32'h10, 32'h12345678, 4'b1000, 32'h0, 1'b1, 1'b0, 32'h0);

        // Reset during the MERGE cycle of a byte store must abort it cleanly.
        preload();
        issue(1'b1, 32'h11, 32'hFFFFFF55, 4'b0001, rc, wc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_rsp_data.delete();
        exp_rsp_err.delete();
        exp_rd_addr.delete();
        exp_wr_addr.delete();
        exp_wr_data.delete();
        lit_rdata.delete();
        lit_err.delete();
        lit_wdata.delete();
        busy_from = -1;
        busy_until = -1;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pulse_idle_check(1'b1);
        run(1'b0, 32'h10, 32'h0, 4'b0111, 32'hA1B2C3D4, 1'b0, 1'b0, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
